// File: rtl/spi_fb_loader.sv
// spi_fb_loader: decodes received SPI command bytes (set address, burst write,
// fill) into single-cycle framebuffer writes with an auto-incrementing pointer.
module spi_fb_loader #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned FB_DEPTH = 9600,
  parameter int unsigned TIMEOUT  = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_wad,
  output logic [7:0]        fb_din,
  output logic              busy,
  output logic              err,
  output logic [7:0]        status
);
  localparam int unsigned       TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR_HI  = 3'd1,
    ADDR_LO  = 3'd2,
    LEN      = 3'd3,
    DATA     = 3'd4,
    FILL_VAL = 3'd5,
    FILL     = 3'd6
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n, wad_n, ptr_inc, addr_val;
  logic [7:0]        addr_hi, addr_hi_n, fill_val, fill_val_n, din_n;
  logic [8:0]        count, count_n;
  logic [TMO_W-1:0]  tmo_cnt, tmo_n;
  logic              we_n, busy_n, err_n;
  logic              counting, expired;

  assign ptr_inc  = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
  assign addr_val = ADDR_W'({addr_hi, rx_byte});
  assign counting = state inside {ADDR_HI, ADDR_LO, LEN, DATA, FILL_VAL};
  assign expired  = counting && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign status   = {busy, err, 3'b000, state};

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    addr_hi_n  = addr_hi;
    fill_val_n = fill_val;
    count_n    = count;
    we_n       = 1'b0;
    wad_n      = fb_wad;
    din_n      = fb_din;
    busy_n     = busy;
    err_n      = err;
    if (rx_valid || !counting) tmo_n = '0;
    else                       tmo_n = tmo_cnt + TMO_W'(1);

    unique case (state)
      IDLE: if (rx_valid) begin
        case (rx_byte)
          8'hA0:   begin state_n = ADDR_HI;  err_n = 1'b0; end
          8'hB0:   begin state_n = LEN;      err_n = 1'b0; end
          8'hC0:   begin state_n = FILL_VAL; err_n = 1'b0; end
          8'h00:   err_n = 1'b0;
          default: err_n = 1'b1;
        endcase
      end
      ADDR_HI: if (rx_valid) begin
        addr_hi_n = rx_byte;
        state_n   = ADDR_LO;
      end
      ADDR_LO: if (rx_valid) begin
        if (32'(addr_val) >= FB_DEPTH) begin
          ptr_n = '0;
          err_n = 1'b1;
        end else begin
          ptr_n = addr_val;
        end
        state_n = IDLE;
      end
      LEN: if (rx_valid) begin
        count_n = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
        state_n = DATA;
      end
      DATA: if (rx_valid) begin
        we_n    = 1'b1;
        wad_n   = ptr;
        din_n   = rx_byte;
        ptr_n   = ptr_inc;
        count_n = count - 9'd1;
        if (count == 9'd1) state_n = IDLE;
      end
      FILL_VAL: if (rx_valid) begin
        fill_val_n = rx_byte;
        ptr_n      = '0;
        busy_n     = 1'b1;
        state_n    = FILL;
      end
      FILL: begin
        we_n  = 1'b1;
        wad_n = ptr;
        din_n = fill_val;
        ptr_n = ptr_inc;
        if (rx_valid) err_n = 1'b1;
        if (ptr == LAST_ADDR) begin
          ptr_n   = '0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase

    // Abandoning a partial command: address halves latched so far are never committed.
    if (expired) begin
      state_n = IDLE;
      err_n   = 1'b1;
      tmo_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      addr_hi  <= '0;
      fill_val <= '0;
      count    <= '0;
      tmo_cnt  <= '0;
      fb_we    <= 1'b0;
      fb_wad   <= '0;
      fb_din   <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      addr_hi  <= addr_hi_n;
      fill_val <= fill_val_n;
      count    <= count_n;
      tmo_cnt  <= tmo_n;
      fb_we    <= we_n;
      fb_wad   <= wad_n;
      fb_din   <= din_n;
      busy     <= busy_n;
      err      <= err_n;
    end
  end
endmodule
